a2_data_out_arbiter: RTL and testbench

//  Downstream of the slot/card slaves (card ROM, soft-switch regs, etc.); merges their data_o/rd_en/inh_n.

---
 rtl/a2_arb_pkg.sv | 22 ++
 rtl/a2_phase_timer.sv | 57 +++++
 rtl/a2_data_out_arbiter.sv | 157 +++++++++++++++
 tb/tb_a2_data_out_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2_arb_pkg.sv
// Shared types and helpers for the Apple II data-out arbiter.
package a2_arb_pkg;

  localparam int DEFAULT_NUM_SRC = 4;
  // Widest source vector the priority helper accepts.
  localparam int MAX_SRC         = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    DRIVE,
    HOLD,
    WAIT
  } arb_state_e;

  // The lowest-index set bit survives and every other bit is cleared,
  // because index 0 has the highest priority.
  function automatic logic [MAX_SRC-1:0] prio_onehot(input logic [MAX_SRC-1:0] req);
    return req & (~req + MAX_SRC'(1));
  endfunction

endpackage

// File: rtl/a2_phase_timer.sv
// Phi0 edge detector and shared setup/hold cycle counter.
// The arbiter FSM tells the timer which phase it is in. The timer returns
// single-cycle strobes: rise, fall, sample (end of setup) and hold_done.
// SETUP_CYCLES and HOLD_CYCLES must both be at least 1.
module a2_phase_timer
  import a2_arb_pkg::*;
#(
  parameter int SETUP_CYCLES = 3,
  parameter int HOLD_CYCLES  = 2
) (
  input  logic clk_logic,
  input  logic system_reset,
  input  logic phi0_i,
  input  logic in_setup_i,
  input  logic in_hold_i,
  output logic rise_o,
  output logic fall_o,
  output logic sample_o,
  output logic hold_done_o
);

  localparam int CNT_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

  logic             phi0_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // phi0_i is already synchronised, so one registered copy is enough for edge detection.
  assign rise_o      = phi0_i & ~phi0_q;
  assign fall_o      = ~phi0_i & phi0_q;
  assign sample_o    = in_setup_i & phi0_i & (cnt_q == SETUP_LAST);
  assign hold_done_o = in_hold_i & (cnt_q == HOLD_LAST);

  // The counter runs only in SETUP and HOLD. It returns to zero when either
  // phase ends, so a direct HOLD->SETUP hand-off starts counting from zero.
  always_comb begin
    cnt_d = '0;
    if ((in_setup_i || in_hold_i) && !hold_done_o && !sample_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Register the phi0 copy and the counter.
  always_ff @(posedge clk_logic) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (system_reset) begin
      phi0_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      phi0_q <= phi0_i;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/a2_data_out_arbiter.sv
// Apple II data-out arbiter: grants one slave source per read cycle and
// times the transceiver drive to phi0. It also merges INH# from all sources.
// Optional feature: define A2_ARB_CONFLICT_LOG_EN to add a saturating
// 16-bit conflict_count_o output.
module a2_data_out_arbiter
  import a2_arb_pkg::*;
#(
  parameter int NUM_SRC      = DEFAULT_NUM_SRC,  // must not exceed MAX_SRC
  parameter int SETUP_CYCLES = 3,
  parameter int HOLD_CYCLES  = 2
) (
  input  logic                    clk_logic,
  input  logic                    system_reset,
  input  logic                    phi0_i,
  input  logic                    rw_n_i,
  input  logic [NUM_SRC-1:0]      src_rd_en_i,
  input  logic [NUM_SRC-1:0][7:0] src_data_i,
  input  logic [NUM_SRC-1:0]      src_inh_n_i,
  output logic [7:0]              data_o,
  output logic                    data_oe_o,
  output logic                    inh_n_o,
  output logic [NUM_SRC-1:0]      grant_o,
  output logic                    conflict_o
`ifdef A2_ARB_CONFLICT_LOG_EN
  ,
  output logic [15:0]             conflict_count_o
`endif
);

  arb_state_e         state_q;
  logic [NUM_SRC-1:0] grant_q;
  logic [7:0]         data_q;
  logic               oe_q;
  logic               inh_n_q;
  logic               conflict_q;
  logic               pend_rise_q;

  logic               rise, fall, sample, hold_done;
  logic [NUM_SRC-1:0] req_onehot;
  logic               multi_req;
  logic [7:0]         req_data, grant_data;

  a2_phase_timer #(
    .SETUP_CYCLES (SETUP_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES)
  ) u_timer (
    .clk_logic    (clk_logic),
    .system_reset (system_reset),
    .phi0_i       (phi0_i),
    .in_setup_i   (state_q == SETUP),
    .in_hold_i    (state_q == HOLD),
    .rise_o       (rise),
    .fall_o       (fall),
    .sample_o     (sample),
    .hold_done_o  (hold_done)
  );

  assign req_onehot = NUM_SRC'(prio_onehot(MAX_SRC'(src_rd_en_i)));
  assign multi_req  = ($countones(src_rd_en_i) > 1);

  // One-hot data muxes: one for the source about to be granted and one for the source already holding the grant.
  always_comb begin
    req_data   = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      req_data   |= src_data_i[i] & {8{req_onehot[i]}};
      grant_data |= src_data_i[i] & {8{grant_q[i]}};
    end
  end

  // Bus-cycle FSM with registered grant, output enable, data and conflict pulse.
  always_ff @(posedge clk_logic) begin
    if (system_reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      data_q      <= 8'h00;
      oe_q        <= 1'b0;
      conflict_q  <= 1'b0;
      pend_rise_q <= 1'b0;
    end else begin
      conflict_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rise) state_q <= SETUP;
        end
        SETUP: begin
          // A short high phase abandons the cycle without driving the bus.
          if (!phi0_i) begin
            state_q <= IDLE;
          end else if (sample) begin
            if (rw_n_i && (|src_rd_en_i)) begin
              state_q    <= DRIVE;
              grant_q    <= req_onehot;
              data_q     <= req_data;
              oe_q       <= 1'b1;
              conflict_q <= multi_req;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        DRIVE: begin
          // The grant is held for the whole cycle even if the source drops rd_en.
          if (fall) begin
            state_q     <= HOLD;
            pend_rise_q <= 1'b0;
          end else begin
            data_q <= grant_data;
          end
        end
        HOLD: begin
          if (rise)      pend_rise_q <= 1'b1;
          else if (fall) pend_rise_q <= 1'b0;
          if (hold_done) begin
            // NOTE: data_o keeps its last value when the drive ends; only reset clears it.
            oe_q        <= 1'b0;
            grant_q     <= '0;
            pend_rise_q <= 1'b0;
            state_q     <= ((pend_rise_q && !fall) || rise) ? SETUP : IDLE;
          end
        end
        WAIT: begin
          if (fall) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Combined INH#: AND of all sources, registered every cycle regardless of FSM state.
  always_ff @(posedge clk_logic) begin
    if (system_reset) inh_n_q <= 1'b1;
    else              inh_n_q <= &src_inh_n_i;
  end

`ifdef A2_ARB_CONFLICT_LOG_EN
  logic [15:0] conflict_count_q;

  // Saturating count of conflict pulses.
  always_ff @(posedge clk_logic) begin
    if (system_reset) begin
      conflict_count_q <= 16'h0000;
    end else if (conflict_q && (conflict_count_q != 16'hFFFF)) begin
      conflict_count_q <= conflict_count_q + 16'h0001;
    end
  end

  assign conflict_count_o = conflict_count_q;
`endif

  assign data_o     = data_q;
  assign data_oe_o  = oe_q;
  assign inh_n_o    = inh_n_q;
  assign grant_o    = grant_q;
  assign conflict_o = conflict_q;

endmodule

// File: tb/tb_a2_data_out_arbiter.sv
// Self-checking bench for a2_data_out_arbiter. It uses directed scenarios
// plus randomized bus cycles, checked against a per-cycle behavioural model.
module tb_a2_data_out_arbiter;

  localparam int NUM_SRC      = 4;
  localparam int SETUP_CYCLES = 3;
  localparam int HOLD_CYCLES  = 2;
  // Steps after raising phi0 at which the grant first becomes visible.
  localparam int GRANT_STEP   = SETUP_CYCLES + 1;

  logic                    clk_logic = 1'b0;
  logic                    system_reset;
  logic                    phi0_i;
  logic                    rw_n_i;
  logic [NUM_SRC-1:0]      src_rd_en_i;
  logic [NUM_SRC-1:0][7:0] src_data_i;
  logic [NUM_SRC-1:0]      src_inh_n_i;
  logic [7:0]              data_o;
  logic                    data_oe_o;
  logic                    inh_n_o;
  logic [NUM_SRC-1:0]      grant_o;
  logic                    conflict_o;
`ifdef A2_ARB_CONFLICT_LOG_EN
  logic [15:0]             conflict_count_o;
  int                      exp_conf_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  a2_data_out_arbiter #(
    .NUM_SRC      (NUM_SRC),
    .SETUP_CYCLES (SETUP_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES)
  ) dut (
    .clk_logic        (clk_logic),
    .system_reset     (system_reset),
    .phi0_i           (phi0_i),
    .rw_n_i           (rw_n_i),
    .src_rd_en_i      (src_rd_en_i),
    .src_data_i       (src_data_i),
    .src_inh_n_i      (src_inh_n_i),
    .data_o           (data_o),
    .data_oe_o        (data_oe_o),
    .inh_n_o          (inh_n_o),
    .grant_o          (grant_o),
    .conflict_o       (conflict_o)
`ifdef A2_ARB_CONFLICT_LOG_EN
    ,
    .conflict_count_o (conflict_count_o)
`endif
  );

  always #5 clk_logic = ~clk_logic;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Observations collected over one phi0 cycle.
  int             obs_oe_on_step, obs_oe_off_step, obs_conf_pulses;
  logic [NUM_SRC-1:0] obs_grant, obs_grant_any;
  logic [7:0]     obs_data;

  task automatic step();
    @(posedge clk_logic);
    #1;
  endtask

  // Drives one phi0 cycle: `hi` clocks high, then `lo` clocks low. Records what the DUT did.
  task automatic run_phase(input int hi, input int lo);
    obs_oe_on_step  = 0;
    obs_oe_off_step = 0;
    obs_conf_pulses = 0;
    obs_grant       = '0;
    obs_grant_any   = '0;
    obs_data        = 8'h00;
    phi0_i = 1'b1;
    for (int s = 1; s <= hi; s++) begin
      step();
      if (data_oe_o && obs_oe_on_step == 0) obs_oe_on_step = s;
      if (s == GRANT_STEP) begin
        obs_grant = grant_o;
        obs_data  = data_o;
      end
      obs_grant_any |= grant_o;
      if (conflict_o) obs_conf_pulses++;
    end
    phi0_i = 1'b0;
    for (int s = 1; s <= lo; s++) begin
      step();
      if (!data_oe_o && obs_oe_off_step == 0) obs_oe_off_step = s;
      obs_grant_any |= grant_o;
      if (conflict_o) obs_conf_pulses++;
    end
  endtask

  // Reference model: a read with any request that survives the setup window
  // grants the lowest-index requester.
  function automatic logic [NUM_SRC-1:0] model_grant(input logic rw, input logic [NUM_SRC-1:0] req,
                                                     input int hi);
    if (!rw || hi < GRANT_STEP) return '0;
    for (int i = 0; i < NUM_SRC; i++) if (req[i]) return NUM_SRC'(1 << i);
    return '0;
  endfunction

  function automatic int model_popcount(input logic [NUM_SRC-1:0] v);
    int n = 0;
    for (int i = 0; i < NUM_SRC; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic test_reset();
    system_reset = 1'b1;
    phi0_i       = 1'b0;
    rw_n_i       = 1'b1;
    src_rd_en_i  = '0;
    src_data_i   = '0;
    src_inh_n_i  = '0;
    repeat (3) step();
    tests_run++;
    if (data_o !== 8'h00)  begin tests_failed++; $display("FAIL reset_data: got %h required 00", data_o); end
    tests_run++;
    if (data_oe_o !== 1'b0) begin tests_failed++; $display("FAIL reset_oe: got %b required 0", data_oe_o); end
    tests_run++;
    if (inh_n_o !== 1'b1)  begin tests_failed++; $display("FAIL reset_inh: got %b required 1", inh_n_o); end
    tests_run++;
    if (grant_o !== '0)    begin tests_failed++; $display("FAIL reset_grant: got %b required 0000", grant_o); end
    tests_run++;
    if (conflict_o !== 1'b0) begin tests_failed++; $display("FAIL reset_conflict: got %b required 0", conflict_o); end
`ifdef A2_ARB_CONFLICT_LOG_EN
    exp_conf_cnt = 0;
    tests_run++;
    if (conflict_count_o !== 16'h0000) begin tests_failed++; $display("FAIL reset_count: got %h required 0000", conflict_count_o); end
`endif
    src_inh_n_i  = '1;
    system_reset = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_single_read();
    rw_n_i      = 1'b1;
    src_rd_en_i = 4'b0010;
    src_data_i  = '0;
    src_data_i[1] = 8'hA5;
    run_phase(14, 5);
    tests_run++;
    if (obs_grant !== 4'b0010) begin tests_failed++; $display("FAIL t1_grant: got %b required 0010", obs_grant); end
    tests_run++;
    if (obs_oe_on_step != GRANT_STEP) begin tests_failed++; $display("FAIL t1_oe_on: got step %0d required %0d", obs_oe_on_step, GRANT_STEP); end
    tests_run++;
    if (obs_data !== 8'hA5) begin tests_failed++; $display("FAIL t1_data: got %h required a5", obs_data); end
    tests_run++;
    if (obs_oe_off_step != HOLD_CYCLES + 1) begin tests_failed++; $display("FAIL t1_oe_off: got step %0d required %0d", obs_oe_off_step, HOLD_CYCLES + 1); end
    tests_run++;
    if (obs_conf_pulses != 0) begin tests_failed++; $display("FAIL t1_conflict: got %0d pulses required 0", obs_conf_pulses); end
  endtask

  task automatic test_conflict();
    rw_n_i      = 1'b1;
    src_rd_en_i = 4'b0101;
    src_data_i  = '0;
    src_data_i[0] = 8'h3C;
    src_data_i[2] = 8'hC3;
    run_phase(10, 5);
    tests_run++;
    if (obs_grant !== 4'b0001) begin tests_failed++; $display("FAIL t2_grant: got %b required 0001", obs_grant); end
    tests_run++;
    if (obs_data !== 8'h3C) begin tests_failed++; $display("FAIL t2_data: got %h required 3c", obs_data); end
    tests_run++;
    if (obs_conf_pulses != 1) begin tests_failed++; $display("FAIL t2_conflict: got %0d pulses required 1", obs_conf_pulses); end
`ifdef A2_ARB_CONFLICT_LOG_EN
    exp_conf_cnt++;
    tests_run++;
    if (conflict_count_o !== 16'(exp_conf_cnt)) begin tests_failed++; $display("FAIL t2_count: got %0d required %0d", conflict_count_o, exp_conf_cnt); end
`endif
  endtask

  task automatic test_write_cycle();
    rw_n_i      = 1'b0;
    src_rd_en_i = 4'b0001;
    src_data_i[0] = 8'h77;
    run_phase(10, 5);
    tests_run++;
    if (obs_oe_on_step != 0) begin tests_failed++; $display("FAIL t3_oe: got oe at step %0d required never", obs_oe_on_step); end
    tests_run++;
    if (obs_grant_any !== '0) begin tests_failed++; $display("FAIL t3_grant: got %b required 0000", obs_grant_any); end
    rw_n_i = 1'b1;
  endtask

  task automatic test_short_phase();
    rw_n_i      = 1'b1;
    src_rd_en_i = 4'b0010;
    src_data_i[1] = 8'h5E;
    run_phase(2, 4);
    tests_run++;
    if (obs_grant_any !== '0 || obs_oe_on_step != 0) begin
      tests_failed++; $display("FAIL t4_short: got grant %b oe_step %0d required 0000/0", obs_grant_any, obs_oe_on_step);
    end
    // The FSM must have returned to IDLE, so a normal cycle times exactly as usual.
    run_phase(8, 5);
    tests_run++;
    if (obs_grant !== 4'b0010 || obs_oe_on_step != GRANT_STEP) begin
      tests_failed++; $display("FAIL t4_recover: got grant %b oe_step %0d required 0010/%0d", obs_grant, obs_oe_on_step, GRANT_STEP);
    end
  endtask

  task automatic test_data_track();
    rw_n_i      = 1'b1;
    src_rd_en_i = 4'b0100;
    src_data_i  = '0;
    src_data_i[2] = 8'h11;
    phi0_i = 1'b1;
    repeat (GRANT_STEP) step();
    tests_run++;
    if (data_o !== 8'h11) begin tests_failed++; $display("FAIL t5_first: got %h required 11", data_o); end
    src_data_i[2] = 8'h22;
    step();
    tests_run++;
    if (data_o !== 8'h22) begin tests_failed++; $display("FAIL t5_track: got %h required 22", data_o); end
    src_rd_en_i = 4'b0000;   // dropping rd_en must not cancel the drive
    step();
    tests_run++;
    if (data_oe_o !== 1'b1 || grant_o !== 4'b0100) begin
      tests_failed++; $display("FAIL t5_keep: got oe %b grant %b required 1/0100", data_oe_o, grant_o);
    end
    phi0_i = 1'b0;
    src_data_i[2] = 8'h33;
    repeat (HOLD_CYCLES) step();
    tests_run++;
    if (data_o !== 8'h22) begin tests_failed++; $display("FAIL t5_frozen: got %h required 22", data_o); end
    step();
    tests_run++;
    if (data_oe_o !== 1'b0 || data_o !== 8'h22) begin
      tests_failed++; $display("FAIL t5_release: got oe %b data %h required 0/22", data_oe_o, data_o);
    end
    repeat (2) step();
  endtask

  task automatic test_back_to_back();
    rw_n_i      = 1'b1;
    src_rd_en_i = 4'b1000;
    src_data_i[3] = 8'h9D;
    run_phase(8, 0);
    // phi0 is now low: one clock low, then high again while HOLD is still running.
    step();
    phi0_i = 1'b1;
    step();
    tests_run++;
    if (data_oe_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_hold: got oe %b required 1", data_oe_o); end
    step();
    tests_run++;
    if (data_oe_o !== 1'b0 || grant_o !== '0) begin
      tests_failed++; $display("FAIL b2b_release: got oe %b grant %b required 0/0000", data_oe_o, grant_o);
    end
    repeat (SETUP_CYCLES - 1) step();
    tests_run++;
    if (grant_o !== '0) begin tests_failed++; $display("FAIL b2b_early: got %b required 0000", grant_o); end
    step();
    tests_run++;
    if (grant_o !== 4'b1000 || data_oe_o !== 1'b1 || data_o !== 8'h9D) begin
      tests_failed++; $display("FAIL b2b_regrant: got grant %b oe %b data %h required 1000/1/9d", grant_o, data_oe_o, data_o);
    end
    phi0_i = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_reset_mid_drive();
    rw_n_i      = 1'b1;
    src_rd_en_i = 4'b0010;
    src_data_i[1] = 8'h5A;
    src_inh_n_i = '1;
    phi0_i = 1'b1;
    repeat (GRANT_STEP + 2) step();
    tests_run++;
    if (data_oe_o !== 1'b1) begin tests_failed++; $display("FAIL t6_pre: got oe %b required 1", data_oe_o); end
    system_reset = 1'b1;
    step();
    system_reset = 1'b0;
    phi0_i       = 1'b0;
    tests_run++;
    if (data_oe_o !== 1'b0 || grant_o !== '0 || inh_n_o !== 1'b1 || data_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL t6_reset: got oe %b grant %b inh %b data %h required 0/0000/1/00", data_oe_o, grant_o, inh_n_o, data_o);
    end
`ifdef A2_ARB_CONFLICT_LOG_EN
    exp_conf_cnt = 0;
    tests_run++;
    if (conflict_count_o !== 16'h0000) begin tests_failed++; $display("FAIL t6_count: got %h required 0000", conflict_count_o); end
`endif
    src_inh_n_i = 4'b0111;
    step();
    tests_run++;
    if (inh_n_o !== 1'b0) begin tests_failed++; $display("FAIL t6_inh: got %b required 0", inh_n_o); end
    src_inh_n_i = '1;
    repeat (3) step();
  endtask

  task automatic test_random();
    int                 hi, lo, idx;
    logic               rw;
    logic [NUM_SRC-1:0] req, inh, eg;
    logic [7:0]         ed;
    for (int n = 0; n < 24; n++) begin
      hi  = $urandom_range(2, 10);
      lo  = $urandom_range(HOLD_CYCLES + 2, 6);
      rw  = ($urandom_range(0, 3) != 0);
      req = NUM_SRC'($urandom);
      inh = ($urandom_range(0, 1) != 0) ? '1 : NUM_SRC'($urandom);
      rw_n_i      = rw;
      src_rd_en_i = req;
      src_inh_n_i = inh;
      for (int i = 0; i < NUM_SRC; i++) src_data_i[i] = 8'($urandom);
      eg  = model_grant(rw, req, hi);
      idx = 0;
      for (int i = 0; i < NUM_SRC; i++) if (eg[i]) idx = i;
      ed  = src_data_i[idx];
      run_phase(hi, lo);
      tests_run++;
      if (obs_grant !== eg || obs_grant_any !== eg) begin
        tests_failed++; $display("FAIL rnd%0d_grant: got %b/%b required %b", n, obs_grant, obs_grant_any, eg);
      end
      tests_run++;
      if (obs_oe_on_step != ((eg != '0) ? GRANT_STEP : 0)) begin
        tests_failed++; $display("FAIL rnd%0d_oe_on: got step %0d required %0d", n, obs_oe_on_step, (eg != '0) ? GRANT_STEP : 0);
      end
      tests_run++;
      if (obs_oe_off_step != ((eg != '0) ? HOLD_CYCLES + 1 : 1)) begin
        tests_failed++; $display("FAIL rnd%0d_oe_off: got step %0d required %0d", n, obs_oe_off_step, (eg != '0) ? HOLD_CYCLES + 1 : 1);
      end
      if (eg != '0) begin
        tests_run++;
        if (obs_data !== ed) begin tests_failed++; $display("FAIL rnd%0d_data: got %h required %h", n, obs_data, ed); end
      end
      tests_run++;
      if (obs_conf_pulses != (((eg != '0) && model_popcount(req) > 1) ? 1 : 0)) begin
        tests_failed++; $display("FAIL rnd%0d_conflict: got %0d pulses for req %b", n, obs_conf_pulses, req);
      end
      tests_run++;
      if (inh_n_o !== (&inh)) begin tests_failed++; $display("FAIL rnd%0d_inh: got %b required %b", n, inh_n_o, &inh); end
`ifdef A2_ARB_CONFLICT_LOG_EN
      if ((eg != '0) && model_popcount(req) > 1) exp_conf_cnt++;
      tests_run++;
      if (conflict_count_o !== 16'(exp_conf_cnt)) begin
        tests_failed++; $display("FAIL rnd%0d_count: got %0d required %0d", n, conflict_count_o, exp_conf_cnt);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_conflict();
    test_write_cycle();
    test_short_phase();
    test_data_track();
    test_back_to_back();
    test_reset_mid_drive();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
